// File: rtl/ptw_walker.sv
// Sv39 page-table walker: one walk at a time, up to three PTE reads, returns a leaf PTE or a fault.
// All outputs decode from state/registers, so no mem_resp_* to resp_* combinational path exists.
module ptw_walker #(
    parameter int unsigned PPN_W = 44,
    parameter int unsigned VPN_W = 27
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               req_valid_i,
    input  logic [VPN_W-1:0]   req_vpn_i,
    output logic               ptw_ready_o,
    input  logic [PPN_W-1:0]   satp_ppn_i,
    input  logic               flush_i,
    output logic               mem_req_valid_o,
    input  logic               mem_req_ready_i,
    output logic [PPN_W+11:0]  mem_req_addr_o,
    input  logic               mem_resp_valid_i,
    input  logic [63:0]        mem_resp_data_i,
    output logic               resp_valid_o,
    output logic               resp_error_o,
    output logic [63:0]        resp_pte_o,
    output logic [1:0]         resp_level_o
);

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StMemReq  = 3'd1;
    localparam logic [2:0] StMemWait = 3'd2;
    localparam logic [2:0] StDone    = 3'd3;
    localparam logic [2:0] StDrain   = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [VPN_W-1:0] vpn_q, vpn_d;
    logic [PPN_W-1:0] ppn_q, ppn_d;
    logic [1:0]       level_q, level_d;
    logic [63:0]      pte_q, pte_d;
    logic [1:0]       res_level_q, res_level_d;
    logic             err_q, err_d;

    logic [8:0] vpn_slice;
    logic       pte_v, pte_r, pte_w, pte_x;
    logic       misaligned;

    assign pte_v = mem_resp_data_i[0];
    assign pte_r = mem_resp_data_i[1];
    assign pte_w = mem_resp_data_i[2];
    assign pte_x = mem_resp_data_i[3];

    // A superpage leaf must have its lower PPN fields zero.
    assign misaligned = ((level_q == 2'd2) && (|mem_resp_data_i[27:10])) ||
                        ((level_q == 2'd1) && (|mem_resp_data_i[18:10]));

    always_comb begin
        case (level_q)
            2'd2:    vpn_slice = vpn_q[18 +: 9];
            2'd1:    vpn_slice = vpn_q[9 +: 9];
            default: vpn_slice = vpn_q[0 +: 9];
        endcase
    end

    always_comb begin
        state_d     = state_q;
        vpn_d       = vpn_q;
        ppn_d       = ppn_q;
        level_d     = level_q;
        pte_d       = pte_q;
        res_level_d = res_level_q;
        err_d       = err_q;
        case (state_q)
            StIdle: begin
                if (req_valid_i && !flush_i) begin
                    vpn_d   = req_vpn_i;
                    ppn_d   = satp_ppn_i;
                    level_d = 2'd2;
                    state_d = StMemReq;
                end
            end
            StMemReq: begin
                if (mem_req_ready_i) begin
                    state_d = flush_i ? StDrain : StMemWait;
                end else if (flush_i) begin
                    state_d = StIdle;
                end
            end
            StMemWait: begin
                if (mem_resp_valid_i) begin
                    if (flush_i) begin
                        state_d = StIdle;
                    end else begin
                        // Default to a fault; only a good leaf or a pointer overrides it.
                        state_d     = StDone;
                        err_d       = 1'b1;
                        pte_d       = '0;
                        res_level_d = '0;
                        if (!pte_v || (!pte_r && pte_w)) begin
                            err_d = 1'b1;
                        end else if (pte_r || pte_x) begin
                            if (!misaligned) begin
                                err_d       = 1'b0;
                                pte_d       = mem_resp_data_i;
                                res_level_d = level_q;
                            end
                        end else if (level_q != 2'd0) begin
                            ppn_d   = mem_resp_data_i[10 +: PPN_W];
                            level_d = level_q - 2'd1;
                            state_d = StMemReq;
                        end
                    end
                end else if (flush_i) begin
                    state_d = StDrain;
                end
            end
            StDone:  state_d = StIdle;
            StDrain: begin
                if (mem_resp_valid_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q     <= StIdle;
            vpn_q       <= '0;
            ppn_q       <= '0;
            level_q     <= '0;
            pte_q       <= '0;
            res_level_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            vpn_q       <= vpn_d;
            ppn_q       <= ppn_d;
            level_q     <= level_d;
            pte_q       <= pte_d;
            res_level_q <= res_level_d;
            err_q       <= err_d;
        end
    end

    assign ptw_ready_o     = (state_q == StIdle);
    assign mem_req_valid_o = (state_q == StMemReq);
    assign mem_req_addr_o  = mem_req_valid_o ? {ppn_q, vpn_slice, 3'b000} : '0;
    assign resp_valid_o    = (state_q == StDone);
    assign resp_error_o    = resp_valid_o & err_q;
    assign resp_pte_o      = resp_valid_o ? pte_q : '0;
    assign resp_level_o    = resp_valid_o ? res_level_q : '0;

endmodule
